// File: rtl/instr_aligner.sv
// Instruction aligner: splits fetch words into 16-bit parcels and emits whole RV32 instructions.
// Compressed (RVC) support is enabled by defining INSTR_ALIGNER_RVC_EN; otherwise every instruction is 32-bit.
module instr_aligner #(
    parameter int RW          = 64,
    parameter int BUF_PARCELS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          fifo_empty,
    output logic          fifo_rden,
    input  logic [RW-1:0] fifo_dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [31:0]   out_pc,
    output logic          out_compressed
);

    logic [BUF_PARCELS-1:0][15:0] par, par_n, shifted;
    logic [2:0]  count, cnt_sh;
    logic [3:0]  cnt_n;
    logic [31:0] bpc, bpc_n;
    logic        inflight;
    logic        is_c, fire;
    logic [1:0]  consumed;
    logic [31:0] row_pc, row_w;

    assign row_pc = fifo_dout[63:32];
    assign row_w  = fifo_dout[31:0];

`ifdef INSTR_ALIGNER_RVC_EN
    assign is_c = (par[0][1:0] != 2'b11);
`else
    assign is_c = 1'b0;
`endif

    always_comb begin
        out_valid      = is_c ? (count >= 3'd1) : (count >= 3'd2);
        out_instr      = is_c ? {16'h0000, par[0]} : {par[1], par[0]};
        out_pc         = bpc;
        out_compressed = out_valid && is_c;
        fire           = out_valid && out_ready;
        consumed       = fire ? (is_c ? 2'd1 : 2'd2) : 2'd0;
    end

    // Read only when the buffer can absorb both the row in flight and the new one.
    assign fifo_rden = rst_n && !flush && !fifo_empty &&
                       ((4'(count) - 4'(consumed) + {2'b00, inflight, 1'b0}) <= 4'd2);

    always_comb begin
        shifted = par >> {consumed, 4'b0000};
        cnt_sh  = count - 3'(consumed);
        par_n   = shifted;
        cnt_n   = {1'b0, cnt_sh};
        bpc_n   = fire ? (bpc + (is_c ? 32'd2 : 32'd4)) : bpc;
        if (inflight) begin
            if (cnt_sh == 3'd0) begin
                bpc_n    = row_pc;
                par_n[0] = row_w[15:0];
                par_n[1] = row_w[31:16];
                cnt_n    = 4'd2;
`ifdef INSTR_ALIGNER_RVC_EN
                // Redirect into the middle of a word: the lower parcel is not ours.
                if (row_pc[1]) begin
                    par_n[0] = row_w[31:16];
                    par_n[1] = shifted[1];
                    cnt_n    = 4'd1;
                end
`endif
            end else begin
                for (int i = 0; i < BUF_PARCELS; i++) begin
                    if (cnt_sh == 3'(i))
                        par_n[i] = row_w[15:0];
                    if (cnt_sh + 3'd1 == 3'(i))
                        par_n[i] = row_w[31:16];
                end
                cnt_n = {1'b0, cnt_sh} + 4'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par      <= '0;
            count    <= 3'd0;
            bpc      <= 32'h0;
            inflight <= 1'b0;
        end else if (flush) begin
            count    <= 3'd0;
            inflight <= 1'b0;
        end else begin
            par      <= par_n;
            count    <= cnt_n[2:0];
            bpc      <= bpc_n;
            inflight <= fifo_rden;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        flush || (cnt_n <= 4'(BUF_PARCELS)));

endmodule

// File: tb/tb_instr_aligner.sv
// Self-checking bench for instr_aligner: table-driven streams plus hand-written corner sequences.
// Expectations follow INSTR_ALIGNER_RVC_EN when it is defined for the build.
module tb_instr_aligner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        fifo_empty;
    logic        fifo_rden;
    logic [63:0] fifo_dout = 64'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_compressed;

    instr_aligner #(.RW(64), .BUF_PARCELS(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .fifo_empty     (fifo_empty),
        .fifo_rden      (fifo_rden),
        .fifo_dout      (fifo_dout),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_compressed (out_compressed)
    );

    always #5 clk = ~clk;

    // Registered-output FIFO model; flush and reset discard everything queued.
    logic [31:0] mem_pc [256];
    logic [31:0] mem_w  [256];
    int wr_ptr;
    int rd_ptr;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_ptr <= wr_ptr;
        else if (flush)
            rd_ptr <= wr_ptr;
        else if (fifo_rden && !fifo_empty) begin
            fifo_dout <= {mem_pc[rd_ptr], mem_w[rd_ptr]};
            rd_ptr    <= rd_ptr + 1;
        end
    end

    typedef struct {
        int          scen;
        logic [31:0] pc;
        logic [31:0] word;
    } row_t;

    typedef struct {
        int          scen;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        c;
    } exp_t;

    row_t rows[$];
    exp_t exps[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] w);
        mem_pc[wr_ptr] = pc;
        mem_w[wr_ptr]  = w;
        wr_ptr++;
    endtask

    task automatic expect_instr(input string name, input logic [31:0] ei, input logic [31:0] ep,
                                input logic ec, input int exp_wait);
        int  w;
        bit  got;
        w   = 0;
        got = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                w   = k;
                got = 1'b1;
                break;
            end
        end
        check({name, "_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({name, "_instr"}, out_instr, ei);
            check({name, "_pc"}, out_pc, ep);
            check({name, "_c"}, 32'(out_compressed), 32'(ec));
            if (exp_wait > 0)
                check({name, "_wait"}, w, exp_wait);
        end
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit first;
        rows.push_back('{0, 32'h100, 32'h00A00093});
        rows.push_back('{0, 32'h104, 32'h00B00113});
        rows.push_back('{0, 32'h108, 32'h00C00193});
        rows.push_back('{1, 32'h200, 32'h00014501});
        rows.push_back('{2, 32'h300, 32'h05134501});
        rows.push_back('{2, 32'h304, 32'h45850000});
        exps.push_back('{0, 32'h00A00093, 32'h100, 1'b0});
        exps.push_back('{0, 32'h00B00113, 32'h104, 1'b0});
        exps.push_back('{0, 32'h00C00193, 32'h108, 1'b0});
`ifdef INSTR_ALIGNER_RVC_EN
        exps.push_back('{1, 32'h00004501, 32'h200, 1'b1});
        exps.push_back('{1, 32'h00000001, 32'h202, 1'b1});
        exps.push_back('{2, 32'h00004501, 32'h300, 1'b1});
        exps.push_back('{2, 32'h00000513, 32'h302, 1'b0});
        exps.push_back('{2, 32'h00004585, 32'h306, 1'b1});
`else
        exps.push_back('{1, 32'h00014501, 32'h200, 1'b0});
        exps.push_back('{2, 32'h05134501, 32'h300, 1'b0});
        exps.push_back('{2, 32'h45850000, 32'h304, 1'b0});
`endif

        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_c", 32'(out_compressed), 32'd0);
        check("rst_rden", 32'(fifo_rden), 32'd0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        for (int s = 0; s < 3; s++) begin
            first = 1'b1;
            foreach (rows[i])
                if (rows[i].scen == s) push(rows[i].pc, rows[i].word);
            foreach (exps[j])
                if (exps[j].scen == s) begin
                    expect_instr($sformatf("s%0d_e%0d", s, j), exps[j].instr, exps[j].pc,
                                 exps[j].c, first ? 2 : 1);
                    first = 1'b0;
                end
            do_flush();
        end

        // Redirect into the upper half of a word; the lone upper parcel must wait for the next row.
        out_ready = 1'b0;
        push(32'h402, 32'h00931234);
        repeat (5) @(negedge clk);
`ifdef INSTR_ALIGNER_RVC_EN
        check("lone_hold_valid", 32'(out_valid), 32'd0);
        push(32'h404, 32'h00010000);
        out_ready = 1'b1;
        expect_instr("redir_0", 32'h00000093, 32'h402, 1'b0, 2);
        expect_instr("redir_1", 32'h00000001, 32'h406, 1'b1, 1);
`else
        check("lone_hold_valid", 32'(out_valid), 32'd1);
        check("lone_hold_instr", out_instr, 32'h00931234);
        check("lone_hold_pc", out_pc, 32'h402);
        push(32'h404, 32'h00010000);
        out_ready = 1'b1;
        expect_instr("redir_1", 32'h00010000, 32'h404, 1'b0, 2);
`endif
        do_flush();

        // Decode stalls with a full FIFO behind the aligner.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            push(32'h500 + 32'(4 * i), 32'h00A00013 + (32'(i) << 16));
        expect_instr("stall_0", 32'h00A00013, 32'h500, 1'b0, 2);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("stall_hold%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("stall_hold%0d_instr", k), out_instr, 32'h00A00013);
            check($sformatf("stall_hold%0d_pc", k), out_pc, 32'h500);
        end
        check("stall_rden_off", 32'(fifo_rden), 32'd0);
        out_ready = 1'b1;
        for (int i = 1; i < 8; i++)
            expect_instr($sformatf("stall_%0d", i), 32'h00A00013 + (32'(i) << 16),
                         32'h500 + 32'(4 * i), 1'b0, 1);
        do_flush();

        // Flush with a row in flight and buffered data.
        for (int i = 0; i < 4; i++)
            push(32'h600 + 32'(4 * i), 32'h00100093 + (32'(i) << 20));
        expect_instr("pre_flush", 32'h00100093, 32'h600, 1'b0, 2);
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_rden", 32'(fifo_rden), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        check("post_flush_valid", 32'(out_valid), 32'd0);
        check("post_flush_rden", 32'(fifo_rden), 32'd0);
        push(32'h800, 32'h00B00093);
        expect_instr("after_flush", 32'h00B00093, 32'h800, 1'b0, 2);

        // Asynchronous reset in the middle of operation.
        out_ready = 1'b0;
        push(32'h900, 32'h00C00093);
        push(32'h904, 32'h00D00093);
        repeat (3) @(negedge clk);
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_instr", out_instr, 32'h0);
        check("midrst_pc", out_pc, 32'h0);
        check("midrst_rden", 32'(fifo_rden), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        push(32'hA00, 32'h00E00093);
        expect_instr("after_reset", 32'h00E00093, 32'hA00, 1'b0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
